// File: rtl/note_envelope_pkg.sv
// Shared types and constants for the note envelope generator.
package note_env_pkg;

  localparam int unsigned LEVEL_W      = 16;
  localparam logic [15:0] MAX_LEVEL    = 16'hFFFF;
  localparam logic [5:0]  SILENCE_CODE = 6'd48;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/note_envelope_if.sv
// Sample-path bus between the tone source and the envelope block.
interface note_envelope_if;

  logic        iSAMPLE_TICK;
  logic        iGATE;
  logic [5:0]  iNOTE;
  logic [15:0] iSAMPLE;
  logic [15:0] oSAMPLE;
  logic        oVALID;
  logic [2:0]  oSTATE;
  logic [15:0] oLEVEL;

  modport master (
    output iSAMPLE_TICK, iGATE, iNOTE, iSAMPLE,
    input  oSAMPLE, oVALID, oSTATE, oLEVEL
  );

  modport slave (
    input  iSAMPLE_TICK, iGATE, iNOTE, iSAMPLE,
    output oSAMPLE, oVALID, oSTATE, oLEVEL
  );

endinterface

// File: rtl/note_envelope_scaler.sv
// Scales a signed sample by the unsigned envelope level and registers the result.
module env_scaler
  import note_env_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [15:0]        sample,
  input  logic [LEVEL_W-1:0] level,
  output logic [15:0]        out_sample,
  output logic               out_valid
);

  logic signed [31:0] sample_ext;
  logic signed [31:0] level_ext;
  logic signed [31:0] product;

  // Level is zero-extended so 16'hFFFF acts as +65535, never as -1.
  assign sample_ext = 32'($signed(sample));
  assign level_ext  = $signed({16'b0, level});
  assign product    = sample_ext * level_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= tick;
      if (tick) begin
        out_sample <= 16'(product >>> 16);
      end
    end
  end

endmodule

// File: rtl/note_envelope.sv
// ADSR-style envelope stepped once per audio sample tick.
// Optional feature: define NOTE_ENV_RETRIG_EN to restart ATTACK when the held note changes.
module note_envelope
  import note_env_pkg::*;
#(
  parameter logic [15:0] ATTACK_INC  = 16'h1000,
  parameter logic [15:0] DECAY_DEC   = 16'h0400,
  parameter logic [15:0] SUSTAIN_LVL = 16'h8000,
  parameter logic [15:0] RELEASE_DEC = 16'h0800
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  note_envelope_if.slave bus
);

  env_state_e         state_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               key_held;
  logic               retrig;
  logic [LEVEL_W:0]   attack_sum;
  logic [LEVEL_W:0]   decay_diff;
  logic [LEVEL_W:0]   release_diff;

  assign key_held     = bus.iGATE && (bus.iNOTE != SILENCE_CODE);
  assign attack_sum   = {1'b0, level_reg} + {1'b0, ATTACK_INC};
  assign decay_diff   = {1'b0, level_reg} - {1'b0, DECAY_DEC};
  assign release_diff = {1'b0, level_reg} - {1'b0, RELEASE_DEC};

`ifdef NOTE_ENV_RETRIG_EN
  logic [5:0] note_reg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      note_reg <= SILENCE_CODE;
    end else if (bus.iSAMPLE_TICK && key_held) begin
      note_reg <= bus.iNOTE;
    end
  end

  assign retrig = key_held && (bus.iNOTE != note_reg);
`else
  assign retrig = 1'b0;
`endif

  // Releasing the key always wins over retrigger and over the natural transitions.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg <= ST_IDLE;
      level_reg <= '0;
    end else if (bus.iSAMPLE_TICK) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (key_held) state_reg <= ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!key_held) begin
            state_reg <= ST_RELEASE;
          end else if (!retrig) begin
            if (attack_sum >= {1'b0, MAX_LEVEL}) begin
              level_reg <= MAX_LEVEL;
              state_reg <= ST_DECAY;
            end else begin
              level_reg <= attack_sum[LEVEL_W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (!key_held) begin
            state_reg <= ST_RELEASE;
          end else if (retrig) begin
            state_reg <= ST_ATTACK;
          end else if (decay_diff[LEVEL_W] || (decay_diff[LEVEL_W-1:0] <= SUSTAIN_LVL)) begin
            level_reg <= SUSTAIN_LVL;
            state_reg <= ST_SUSTAIN;
          end else begin
            level_reg <= decay_diff[LEVEL_W-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!key_held) begin
            state_reg <= ST_RELEASE;
          end else if (retrig) begin
            state_reg <= ST_ATTACK;
          end
        end
        ST_RELEASE: begin
          if (key_held) begin
            state_reg <= ST_ATTACK;
          end else if (release_diff[LEVEL_W] || (release_diff[LEVEL_W-1:0] == '0)) begin
            level_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            level_reg <= release_diff[LEVEL_W-1:0];
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          level_reg <= '0;
        end
      endcase
    end
  end

  // Scaler sees the level before this tick's update.
  env_scaler u_scaler (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .tick       (bus.iSAMPLE_TICK),
    .sample     (bus.iSAMPLE),
    .level      (level_reg),
    .out_sample (bus.oSAMPLE),
    .out_valid  (bus.oVALID)
  );

  assign bus.oSTATE = state_reg;
  assign bus.oLEVEL = level_reg;

endmodule

// File: tb/tb_note_envelope.sv
// Directed, table-driven bench for note_envelope.
module tb_note_envelope;

  logic iCLK;
  logic iRST_N;
  int   checks;
  int   errors;

  note_envelope_if bus ();

  note_envelope dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        tick;
    logic        gate;
    logic [5:0]  note;
    logic [15:0] smp;
    logic [2:0]  st;
    logic [15:0] lvl;
    logic        vld;
    logic [15:0] osmp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_env(input string name, input logic [2:0] st, input logic [15:0] lvl);
    check({name, "_state"}, 16'(bus.oSTATE), 16'(st));
    check({name, "_level"}, bus.oLEVEL, lvl);
  endtask

  // Drive one cycle's inputs just after a falling edge, then sample at the next falling edge.
  task automatic step(input logic t, input logic g, input logic [5:0] n, input logic [15:0] s);
    bus.iSAMPLE_TICK = t;
    bus.iGATE        = g;
    bus.iNOTE        = n;
    bus.iSAMPLE      = s;
    @(negedge iCLK);
    bus.iSAMPLE_TICK = 1'b0;
  endtask

  task automatic run_ticks(input int cnt, input logic g, input logic [5:0] n);
    for (int k = 0; k < cnt; k++) step(1'b1, g, n, 16'h0000);
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    step(1'b0, 1'b0, 6'd48, 16'h0000);
    step(1'b0, 1'b0, 6'd48, 16'h0000);
    check_env("rst", 3'd0, 16'h0000);
    check("rst_sample", bus.oSAMPLE, 16'h0000);
    check("rst_valid", 16'(bus.oVALID), 16'h0000);
    iRST_N = 1'b1;
    step(1'b0, 1'b0, 6'd48, 16'h0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    iRST_N = 1'b0;
    bus.iSAMPLE_TICK = 1'b0;
    bus.iGATE = 1'b0;
    bus.iNOTE = 6'd48;
    bus.iSAMPLE = 16'h0000;

    //           tick gate note   smp       st    lvl       vld   osmp
    vecs[0]  = '{1'b0, 1'b1, 6'd12, 16'h7FFF, 3'd0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 6'd12, 16'h7FFF, 3'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 6'd48, 16'h7FFF, 3'd0, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 6'd12, 16'h4000, 3'd1, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 6'd12, 16'h4000, 3'd1, 16'h1000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 6'd12, 16'h4000, 3'd1, 16'h2000, 1'b1, 16'h0400};
    vecs[6]  = '{1'b0, 1'b0, 6'd12, 16'h1234, 3'd1, 16'h2000, 1'b0, 16'h0400};
    vecs[7]  = '{1'b1, 1'b1, 6'd12, 16'hC000, 3'd1, 16'h3000, 1'b1, 16'hF800};
    vecs[8]  = '{1'b1, 1'b0, 6'd12, 16'h0000, 3'd4, 16'h3000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 6'd12, 16'h7FFF, 3'd4, 16'h2800, 1'b1, 16'h17FF};
    vecs[10] = '{1'b1, 1'b1, 6'd12, 16'h0100, 3'd1, 16'h2800, 1'b1, 16'h0028};
    vecs[11] = '{1'b1, 1'b1, 6'd12, 16'h0000, 3'd1, 16'h3800, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 6'd12, 16'h0000, 3'd1, 16'h3800, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 6'd12, 16'h0000, 3'd4, 16'h3800, 1'b1, 16'h0000};
    vecs[14] = '{1'b1, 1'b0, 6'd12, 16'h0000, 3'd4, 16'h3000, 1'b1, 16'h0000};

    @(negedge iCLK);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].tick, vecs[i].gate, vecs[i].note, vecs[i].smp);
      check_env($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl);
      check($sformatf("vec%0d_valid", i), 16'(bus.oVALID), 16'(vecs[i].vld));
      check($sformatf("vec%0d_sample", i), bus.oSAMPLE, vecs[i].osmp);
      $display("vec%0d tick=%0b gate=%0b note=%0d smp=%h -> st=%0d lvl=%h vld=%0b osmp=%h",
               i, vecs[i].tick, vecs[i].gate, vecs[i].note, vecs[i].smp,
               bus.oSTATE, bus.oLEVEL, bus.oVALID, bus.oSAMPLE);
    end

    // Full attack/decay to sustain
    do_reset();
    run_ticks(16, 1'b1, 6'd12);
    check_env("atk16", 3'd1, 16'hF000);
    run_ticks(1, 1'b1, 6'd12);
    check_env("atk_sat", 3'd2, 16'hFFFF);
    step(1'b1, 1'b1, 6'd12, 16'h8000);
    check("fullscale_sample", bus.oSAMPLE, 16'h8000);
    check_env("dec1", 3'd2, 16'hFBFF);
    run_ticks(30, 1'b1, 6'd12);
    check_env("dec31", 3'd2, 16'h83FF);
    run_ticks(1, 1'b1, 6'd12);
    check_env("sustain", 3'd3, 16'h8000);
    step(1'b1, 1'b1, 6'd12, 16'h4000);
    check("sus_valid", 16'(bus.oVALID), 16'h0001);
    check("sus_sample", bus.oSAMPLE, 16'h2000);
    step(1'b0, 1'b1, 6'd12, 16'h0000);
    check("sus_valid_drop", 16'(bus.oVALID), 16'h0000);
    check("sus_sample_hold", bus.oSAMPLE, 16'h2000);
    $display("seq sustain reached: st=%0d lvl=%h", bus.oSTATE, bus.oLEVEL);

    // Note change while sustaining
    step(1'b1, 1'b1, 6'd19, 16'h0000);
`ifdef NOTE_ENV_RETRIG_EN
    check_env("retrig", 3'd1, 16'h8000);
    run_ticks(7, 1'b1, 6'd19);
    check_env("retrig7", 3'd1, 16'hF000);
    run_ticks(1, 1'b1, 6'd19);
    check_env("retrig8", 3'd2, 16'hFFFF);
    run_ticks(32, 1'b1, 6'd19);
    check_env("retrig_sus", 3'd3, 16'h8000);
`else
    check_env("note_change", 3'd3, 16'h8000);
    run_ticks(2, 1'b1, 6'd12);
    check_env("note_change2", 3'd3, 16'h8000);
`endif
    $display("seq note change: st=%0d lvl=%h", bus.oSTATE, bus.oLEVEL);

    // Release to idle
    run_ticks(1, 1'b0, 6'd19);
    check_env("rel_entry", 3'd4, 16'h8000);
    run_ticks(15, 1'b0, 6'd19);
    check_env("rel15", 3'd4, 16'h0800);
    run_ticks(1, 1'b0, 6'd19);
    check_env("rel_idle", 3'd0, 16'h0000);
    $display("seq release: st=%0d lvl=%h", bus.oSTATE, bus.oLEVEL);

    // Re-press during release
    run_ticks(1, 1'b1, 6'd12);
    check_env("re_atk", 3'd1, 16'h0000);
    run_ticks(4, 1'b1, 6'd12);
    check_env("re_atk4", 3'd1, 16'h4000);
    run_ticks(1, 1'b0, 6'd12);
    check_env("re_rel", 3'd4, 16'h4000);
    run_ticks(1, 1'b1, 6'd12);
    check_env("repress", 3'd1, 16'h4000);
    step(1'b1, 1'b1, 6'd12, 16'h7FFF);
    check_env("repress_next", 3'd1, 16'h5000);
    check("pre_rst_sample", bus.oSAMPLE, 16'h1FFF);
    $display("seq repress: st=%0d lvl=%h osmp=%h", bus.oSTATE, bus.oLEVEL, bus.oSAMPLE);

    // Asynchronous reset between ticks
    iRST_N = 1'b0;
    #1;
    check_env("async_rst", 3'd0, 16'h0000);
    check("async_rst_sample", bus.oSAMPLE, 16'h0000);
    check("async_rst_valid", 16'(bus.oVALID), 16'h0000);
    @(negedge iCLK);
    iRST_N = 1'b1;
    step(1'b0, 1'b0, 6'd12, 16'h0000);
    run_ticks(1, 1'b1, 6'd12);
    check_env("post_rst", 3'd1, 16'h0000);
    run_ticks(1, 1'b1, 6'd12);
    check_env("post_rst2", 3'd1, 16'h1000);
    $display("seq async reset: st=%0d lvl=%h", bus.oSTATE, bus.oLEVEL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_envelope.md
NOTE_ENVELOPE -- requirements
Module: note_envelope

Interface
REQ-001 SHALL have parameter ATTACK_INC, default 16'h1000, level increment per sample tick in ATTACK.
REQ-002 SHALL have parameter DECAY_DEC, default 16'h0400, level decrement per tick in DECAY.
REQ-003 SHALL have parameter SUSTAIN_LVL, default 16'h8000, DECAY floor and SUSTAIN hold level.
REQ-004 SHALL have parameter RELEASE_DEC, default 16'h0800, level decrement per tick in RELEASE.
REQ-005 SHALL have port iCLK, input, 1, the single clock, 50 MHz.
REQ-006 SHALL have port iRST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iSAMPLE_TICK, input, 1, one-cycle strobe per audio sample (DACLRCK edge, already synchronised to iCLK).
REQ-008 SHALL have port iGATE, input, 1, key held.
REQ-009 SHALL have port iNOTE, input, 6, current freq code; 48 means silence.
REQ-010 SHALL have port iSAMPLE, input, 16, signed sine-table sample.
REQ-011 SHALL have port oSAMPLE, output, 16, signed enveloped sample for audio_converter.
REQ-012 SHALL have port oVALID, output, 1, one-cycle pulse when oSAMPLE updates.
REQ-013 SHALL have port oSTATE, output, 3, current envelope state.
REQ-014 SHALL have port oLEVEL, output, 16, current envelope level, unsigned.

Function
REQ-015 SHALL define states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; all state and level updates occur only in cycles with iSAMPLE_TICK=1.
REQ-016 SHALL treat the key as held when iGATE=1 and iNOTE!=48, sampled on the tick; gate activity between ticks is ignored.
REQ-017 IDLE: key held -> ATTACK, level unchanged (0) on that tick.
REQ-018 ATTACK: level += ATTACK_INC, saturating at 16'hFFFF; on saturation -> DECAY.
REQ-019 DECAY: level -= DECAY_DEC, clamped at SUSTAIN_LVL; on reaching SUSTAIN_LVL -> SUSTAIN.
REQ-020 SUSTAIN: level held.
REQ-021 ATTACK/DECAY/SUSTAIN with key not held -> RELEASE on that tick, no level change on that tick; this takes priority over the REQ-018/019 transitions.
REQ-022 RELEASE: level -= RELEASE_DEC, clamped at 0; on reaching 0 -> IDLE; key held in RELEASE -> ATTACK from the current level.
REQ-023 On each tick, oSAMPLE SHALL be bits [31:16] of signed iSAMPLE times {1'b0,level}, using the level from before that tick's update; oSAMPLE and oVALID register 1 cycle after the tick.
REQ-024 Back-to-back ticks SHALL each be processed; oVALID SHALL pulse once per tick.

Reset
REQ-025 iRST_N low SHALL immediately force state IDLE, level 0, oSAMPLE 0, oVALID 0, and stored note 6'd48, including mid-envelope.
REQ-026 After reset release, the first tick SHALL behave as from IDLE.

Configuration
REQ-027 With NOTE_ENV_RETRIG_EN defined: key held and iNOTE differing from the stored note in ATTACK/DECAY/SUSTAIN SHALL -> ATTACK from the current level; the stored note updates on every tick with key held.
REQ-028 Without NOTE_ENV_RETRIG_EN: a note change with key held SHALL NOT alter state or level; the stored-note register is omitted.

Structure
REQ-029 Package note_env_pkg SHALL hold the state enum, LEVEL_W=16, MAX_LEVEL=16'hFFFF, and SILENCE_CODE=6'd48.
REQ-030 Sub-module env_scaler SHALL contain the signed multiply, truncation, and output register; the FSM and level register remain in note_envelope.

Verification
REQ-031 Scenario: reset, then hold key (iNOTE=12) -> 16th tick saturates level to 16'hFFFF with state DECAY; 32 further ticks -> level 16'h8000, state SUSTAIN.
REQ-032 Scenario: SUSTAIN with iSAMPLE=16'h4000 on a tick -> oSAMPLE=16'h2000 with oVALID pulsed 1 cycle later.
REQ-033 Scenario: release gate in SUSTAIN -> state RELEASE; 16 ticks later level 0 and state IDLE; iSAMPLE=16'h8000 at level 16'hFFFF -> oSAMPLE=16'h8000.
REQ-034 Scenario: assert iRST_N=0 mid-ATTACK between ticks -> oLEVEL, oSAMPLE, and oSTATE are 0 with no clock edge.
REQ-035 Scenario: with NOTE_ENV_RETRIG_EN, change iNOTE 12->19 in SUSTAIN -> ATTACK from 16'h8000, reaching 16'hFFFF after 8 ticks; without the macro, state stays SUSTAIN.
REQ-036 Scenario: key released and re-pressed on the same tick gap in RELEASE at level 16'h4000 -> ATTACK, with level 16'h5000 after the next tick.
